// File: rtl/win_kxk_stream_pkg.sv
// Shared helpers for the K x K streaming window generator and its testbench.
package win_kxk_stream_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Bit offset of element (r,c,ch) in the flattened window bus.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned ch, input int unsigned k,
                                            input int unsigned ch_n, input int unsigned pix_bits);
        return ((r * k + c) * ch_n + ch) * pix_bits;
    endfunction

endpackage

// File: rtl/win_kxk_stream_line_buffer.sv
// Circular one-row line buffer: asynchronous read and synchronous write share one column address.
module line_buffer
    import win_kxk_stream_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
    end

    // Read returns the entry written one row earlier, before this beat overwrites it.
    assign rd_data = mem[addr];

endmodule

// File: rtl/win_kxk_stream.sv
// Raster-order pixel stream to K x K (x CH) sliding windows with stride and valid/ready on both sides.
module win_kxk_stream
    import win_kxk_stream_pkg::*;
#(
    parameter int unsigned K          = 5,
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32,
    parameter int unsigned PIX_BITS   = 8,
    parameter int unsigned CH         = 1,
    parameter int unsigned STRIDE     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH*PIX_BITS-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*CH*PIX_BITS-1:0]   win_out,
    output logic                         out_last
);

    localparam int unsigned BEAT_W   = CH * PIX_BITS;
    localparam int unsigned COL_W    = clog2(IMG_WIDTH);
    localparam int unsigned ROW_W    = clog2(IMG_HEIGHT);
    localparam int unsigned PH_W     = clog2(STRIDE + 1);
    localparam int unsigned LAST_ROW = (K - 1) + ((IMG_HEIGHT - K) / STRIDE) * STRIDE;
    localparam int unsigned LAST_COL = (K - 1) + ((IMG_WIDTH - K) / STRIDE) * STRIDE;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PH_W-1:0]  col_ph;
    logic [PH_W-1:0]  row_ph;

    logic accept, emit, last_pos, col_ge, row_ge, end_of_row, end_of_frame;

    logic [BEAT_W-1:0]         lb_rd    [K-1];
    logic [BEAT_W-1:0]         col_vec  [K];
    logic [BEAT_W-1:0]         win      [K][K];
    logic [BEAT_W-1:0]         win_next [K][K];
    logic [K*K*BEAT_W-1:0]     win_flat;

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign col_ge       = col >= COL_W'(K - 1);
    assign row_ge       = row >= ROW_W'(K - 1);
    assign end_of_row   = col == COL_W'(IMG_WIDTH - 1);
    assign end_of_frame = end_of_row && (row == ROW_W'(IMG_HEIGHT - 1));
    assign emit         = row_ge && col_ge && (row_ph == '0) && (col_ph == '0);
    assign last_pos     = (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

    // Phase counters stay at 0 until the window first fits, then cycle 0..STRIDE-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (accept) begin
            if (end_of_row) begin
                col    <= '0;
                col_ph <= '0;
                if (end_of_frame) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= row + 1'b1;
                    row_ph <= (!row_ge || row_ph == PH_W'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
                end
            end else begin
                col    <= col + 1'b1;
                col_ph <= (!col_ge || col_ph == PH_W'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        logic [BEAT_W-1:0] lb_wr;
        if (i == 0) begin : g_head
            assign lb_wr = in_data;
        end else begin : g_tail
            assign lb_wr = lb_rd[i-1];
        end
        line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (BEAT_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col),
            .wr_data (lb_wr),
            .rd_data (lb_rd[i])
        );
    end

    // Newest column: oldest row from the deepest buffer, current row straight from the input.
    always_comb begin
        for (int unsigned r = 0; r < K - 1; r++) col_vec[r] = lb_rd[K-2-r];
        col_vec[K-1] = in_data;
    end

    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) win_next[r][c] = win[r][c+1];
            win_next[r][K-1] = col_vec[r];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_flat[win_idx(r, c, 0, K, CH, PIX_BITS) +: BEAT_W] = win_next[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) win <= win_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            win_out   <= '0;
        end else if (accept && emit) begin
            out_valid <= 1'b1;
            out_last  <= last_pos;
            win_out   <= win_flat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_win_kxk_stream.sv
// Scoreboard bench: instance A (CH=3, STRIDE=1) with directed and random handshakes, instance B (STRIDE=2).
module tb_win_kxk_stream;
    import win_kxk_stream_pkg::*;

    localparam int K    = 5;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int PB   = 8;
    localparam int CH_A = 3;
    localparam int S_A  = 1;
    localparam int CH_B = 1;
    localparam int S_B  = 2;
    localparam int BA   = CH_A * PB;
    localparam int WA   = K * K * BA;
    localparam int WB   = K * K * CH_B * PB;
    localparam int NWIN_A = ((H - K) / S_A + 1) * ((W - K) / S_A + 1);
    localparam int NWIN_B = ((H - K) / S_B + 1) * ((W - K) / S_B + 1);
    localparam int CYC_LIMIT = 1 << (clog2(W * H) + 8);

    logic clk;
    logic rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
    logic [BA-1:0] in_data_a;
    logic [WA-1:0] win_out_a;
    logic rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
    logic [PB-1:0] in_data_b;
    logic [WB-1:0] win_out_b;

    win_kxk_stream #(.K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BITS(PB), .CH(CH_A), .STRIDE(S_A)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .win_out(win_out_a), .out_last(out_last_a));

    win_kxk_stream #(.K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BITS(PB), .CH(CH_B), .STRIDE(S_B)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .win_out(win_out_b), .out_last(out_last_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [WA-1:0] act, input logic [WA-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: whole-frame image arrays, windows cut out with plain index arithmetic.
    typedef struct {
        logic [WA-1:0] win;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [BA-1:0] img [2][H][W];
    int            mr [2] = '{0, 0};
    int            mc [2] = '{0, 0};

    function automatic bit emits(input int r, input int c, input int s);
        if (r < K - 1 || c < K - 1) return 1'b0;
        return ((r - (K - 1)) % s == 0) && ((c - (K - 1)) % s == 0);
    endfunction

    function automatic bit is_last(input int r, input int c, input int s);
        if (!emits(r, c, s)) return 1'b0;
        for (int rr = r; rr < H; rr++)
            for (int cc = 0; cc < W; cc++)
                if ((rr > r || cc > c) && emits(rr, cc, s)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_accept(input int u, input logic [BA-1:0] d);
        exp_t e;
        int s, chn, r0, c0;
        s   = (u == 0) ? S_A : S_B;
        chn = (u == 0) ? CH_A : CH_B;
        img[u][mr[u]][mc[u]] = d;
        if (emits(mr[u], mc[u], s)) begin
            e.win = '0;
            r0 = mr[u] - K + 1;
            c0 = mc[u] - K + 1;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    for (int ch = 0; ch < chn; ch++)
                        e.win[((r * K + c) * chn + ch) * PB +: PB] = img[u][r0 + r][c0 + c][ch * PB +: PB];
            e.last = is_last(mr[u], mc[u], s);
            e.cyc  = cyc + 1;
            if (u == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        if (mc[u] == W - 1) begin
            mc[u] = 0;
            mr[u] = (mr[u] == H - 1) ? 0 : mr[u] + 1;
        end else begin
            mc[u]++;
        end
    endtask

    function automatic logic [BA-1:0] pix(input int base, input int r, input int c);
        logic [BA-1:0] p;
        p[7:0]   = 8'(base + r * W + c);
        p[15:8]  = 8'(64 + c);
        p[23:16] = 8'(128 + c);
        return p;
    endfunction

    // ---------------- instance A stimulus ----------------
    int stall_a = 0;

    task automatic drive_a(input logic v, input logic [BA-1:0] d, input logic ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid_a  = v;
        in_data_a   = v ? d : BA'($urandom);
        out_ready_a = ordy;
        #1;
        acc = v && in_ready_a;
        if (acc) model_accept(0, d);
    endtask

    task automatic send_a(input int base, input bit rnd);
        bit acc;
        logic v, ordy;
        logic [BA-1:0] d;
        int tries;
        d = rnd ? BA'($urandom) : pix(base, mr[0], mc[0]);
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            v    = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            ordy = rnd ? ($urandom_range(0, 9) < 7) : (stall_a == 0);
            if (stall_a > 0) stall_a--;
            drive_a(v, d, ordy, acc);
            tries++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_a: beat (%0d,%0d) not accepted after %0d cycles", mr[0], mc[0], tries);
        end
    endtask

    task automatic frame_a(input int base, input bit rnd, input int stall_after, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            send_a(base, rnd);
            if (i == stall_after) stall_a = 10;
        end
    endtask

    // Ready is held low so the window in flight is pending, not consumed, when reset hits.
    task automatic reset_a();
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        q_a.delete();
        mr[0] = 0;
        mc[0] = 0;
        @(posedge clk);
        #1;
        check("rst_hold_valid", WA'(out_valid_a), WA'(0));
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        check("rst_valid", WA'(out_valid_a), WA'(0));
        check("rst_last", WA'(out_last_a), WA'(0));
        check("rst_win", win_out_a, '0);
        check("rst_in_ready", WA'(in_ready_a), WA'(1));
    endtask

    // ---------------- instance A monitor ----------------
    bit            shown_a = 1'b0;
    logic [WA-1:0] held_a;
    logic          held_last_a;
    int            cnt_a = 0;
    int            n_last_a = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_a) begin
            shown_a = 1'b0;
            cnt_a   = 0;
        end else if (out_valid_a) begin
            if (!shown_a) begin
                shown_a     = 1'b1;
                held_a      = win_out_a;
                held_last_a = out_last_a;
                total++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_a: out_valid=1 at cycle %0d, expected no window", cyc);
                end else if (cyc != q_a[0].cyc) begin
                    bad++;
                    $display("FAIL latency_a: window at cycle %0d expected cycle %0d", cyc, q_a[0].cyc);
                end
            end else begin
                check("stable_win_a", win_out_a, held_a);
                check("stable_last_a", WA'(out_last_a), WA'(held_last_a));
            end
            if (!out_ready_a) check("stall_in_ready_a", WA'(in_ready_a), WA'(0));
            if (out_ready_a && q_a.size() != 0) begin
                e = q_a.pop_front();
                check("win_a", win_out_a, e.win);
                check("last_a", WA'(out_last_a), WA'(e.last));
                shown_a = 1'b0;
                cnt_a++;
                if (out_last_a) begin
                    check("frame_windows_a", WA'(cnt_a), WA'(NWIN_A));
                    cnt_a = 0;
                    n_last_a++;
                end
            end
        end
    end

    // ---------------- instance B: stride 2, always ready ----------------
    bit b_done = 1'b0;
    int cnt_b = 0;
    int n_last_b = 0;

    initial begin
        bit acc;
        int tries;
        rst_b = 1'b1;
        in_valid_b = 1'b0;
        in_data_b = '0;
        out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < W * H; i++) begin
                acc = 1'b0;
                tries = 0;
                while (!acc && tries < 20) begin
                    @(posedge clk);
                    #1;
                    in_valid_b = 1'b1;
                    in_data_b  = 8'(f * 100 + mr[1] * W + mc[1]);
                    #1;
                    acc = in_ready_b;
                    if (acc) model_accept(1, BA'(in_data_b));
                    tries++;
                end
                if (!acc) begin
                    total++;
                    bad++;
                    $display("FAIL accept_b: beat (%0d,%0d) not accepted", mr[1], mc[1]);
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        repeat (4) @(posedge clk);
        b_done = 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && out_valid_b) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL spurious_b: out_valid=1 at cycle %0d, expected no window", cyc);
            end else begin
                e = q_b.pop_front();
                check("win_b", WA'(win_out_b), e.win);
                check("last_b", WA'(out_last_b), WA'(e.last));
                cnt_b++;
                if (out_last_b) begin
                    check("frame_windows_b", WA'(cnt_b), WA'(NWIN_B));
                    cnt_b = 0;
                    n_last_b++;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        rst_a = 1'b1;
        in_valid_a = 1'b0;
        in_data_a = '0;
        out_ready_a = 1'b1;
        reset_a();
        frame_a(0, 1'b0, -1, W * H);
        frame_a(100, 1'b0, -1, W * H);
        frame_a(0, 1'b0, 36, W * H);
        frame_a(0, 1'b0, -1, 6 * W);
        reset_a();
        frame_a(0, 1'b0, -1, W * H);
        repeat (3) frame_a(0, 1'b1, -1, W * H);
        for (int i = 0; i < 6; i++) drive_a(1'b0, '0, 1'b1, acc);
        check("drain_queue_a", WA'(q_a.size()), WA'(0));
        check("frames_a", WA'(n_last_a), WA'(7));
        for (int t = 0; t < 2000 && !b_done; t++) @(posedge clk);
        check("done_b", WA'(b_done), WA'(1));
        check("drain_queue_b", WA'(q_b.size()), WA'(0));
        check("frames_b", WA'(n_last_b), WA'(2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(CYC_LIMIT * 10);
        bad++;
        $display("FAIL watchdog: run exceeded %0d cycles", CYC_LIMIT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/win_kxk_stream.md
WIN_KXK_STREAM -- requirements
Module: win_kxk_stream

Interface
REQ-001 SHALL have parameter K, default 5: window edge in pixels, legal 2..7.
REQ-002 SHALL have parameter IMG_WIDTH, default 32: pixels per row, legal ≥ K.
REQ-003 SHALL have parameter IMG_HEIGHT, default 32: rows per frame, legal ≥ K.
REQ-004 SHALL have parameter PIX_BITS, default 8: signed sample width.
REQ-005 SHALL have parameter CH, default 1: channels carried per pixel beat.
REQ-006 SHALL have parameter STRIDE, default 1: window step in rows and columns, legal 1..K.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port in_valid, input, 1: pixel beat offered.
REQ-010 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-011 SHALL have port in_data, input, CH*PIX_BITS: channel ch at bits [ch*PIX_BITS +: PIX_BITS], signed.
REQ-012 SHALL have port out_valid, output, 1: window held on win_out.
REQ-013 SHALL have port out_ready, input, 1: consumer takes window when out_valid && out_ready.
REQ-014 SHALL have port win_out, output, K*K*CH*PIX_BITS: element (r,c,ch) at [((r*K+c)*CH+ch)*PIX_BITS +: PIX_BITS]; r=0 is the oldest row, c=0 the leftmost column.
REQ-015 SHALL have port out_last, output, 1: qualifies the final window of a frame.

Function
REQ-016 SHALL accept pixels in raster order; col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, both advancing only on accepted beats.
REQ-017 SHALL wrap col to 0 and increment row after col = IMG_WIDTH-1; after (row,col) = (IMG_HEIGHT-1, IMG_WIDTH-1), SHALL wrap both to 0 so the next beat starts a new frame with no idle cycle.
REQ-018 SHALL store the K-1 previous rows in line buffers of IMG_WIDTH entries and keep a K×K×CH register window that shifts left one column per accepted beat.
REQ-019 SHALL emit a window on accepting (row,col) iff row ≥ K-1, col ≥ K-1, (row-(K-1)) mod STRIDE = 0 and (col-(K-1)) mod STRIDE = 0.
REQ-020 SHALL compute the stride test with per-row and per-column phase counters, not dividers.
REQ-021 An emitted window SHALL hold rows row-K+1..row and columns col-K+1..col of the current frame only.
REQ-022 SHALL register win_out, out_valid and out_last one cycle after the accepting edge (latency 1).
REQ-023 in_ready SHALL equal !out_valid || out_ready, combinationally; the module SHALL drop no window and accept no beat it cannot store.
REQ-024 win_out and out_last SHALL stay stable while out_valid && !out_ready.
REQ-025 Output handoff and a new emitting beat in the same cycle SHALL reload the output register with no bubble, sustaining one window per cycle.
REQ-026 out_last SHALL be 1 only with the window emitted at the last qualifying (row,col) of the frame.
REQ-027 in_data SHALL be ignored when in_valid = 0; no arithmetic is applied to samples, and sign bits SHALL be preserved bit-exact.

Reset
REQ-028 While rst = 1, the module SHALL clear out_valid, out_last, win_out, row, col and the phase counters to 0, and in_ready SHALL read 1 after the reset edge.
REQ-029 Line-buffer contents SHALL need no reset; REQ-021 guarantees stale data never reaches win_out.
REQ-030 rst asserted mid-frame SHALL discard any pending window, and the next accepted beat SHALL be treated as (0,0).

Structure
REQ-031 A shared package SHALL hold the CLOG2 function and the win_out index helper; the testbench SHALL use the same package.
REQ-032 A single sub-module line_buffer SHALL implement a circular IMG_WIDTH-deep, CH*PIX_BITS-wide RAM with a shared column address; K-1 instances SHALL be cascaded.

Verification
REQ-033 K=5, W=H=8, CH=1, STRIDE=1; pixel = row*8+col; continuous valid, out_ready=1 -> 16 windows, first one cycle after beat 36 with element (r,c)=r*8+c, out_last only on 16th (origin (3,3)).
REQ-034 Same setup, out_ready=0 for 10 cycles after first window -> in_ready=0 throughout, win_out unchanged, no beat accepted, all 16 windows still correct in order.
REQ-035 K=5, W=H=8, STRIDE=2 -> exactly 4 windows with origins (0,0),(0,2),(2,0),(2,2).
REQ-036 Two back-to-back frames, second frame pixel = 100+row*8+col -> second frame's first window is 100+r*8+c, with no first-frame values present.
REQ-037 rst pulsed after row 5 of frame 1, then a fresh frame -> no out_valid during reset, next output matches REQ-033 exactly.
REQ-038 CH=3, channel ch = ch*64+col, random in_valid/out_ready -> every window matches the reference model bit-exact and no window is lost or duplicated.
